// File: rtl/alu_sweep_driver_pkg.sv
// Shared types and defaults for the ALU sweep driver: widths, FSM state encoding and
// the settle-counter width helper.
package alu_sweep_driver_pkg;

    localparam int unsigned DataWDef  = 8;
    localparam int unsigned OpWDef    = 3;
    localparam int unsigned SettleDef = 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrive  = 2'd1,
        StSettle = 2'd2,
        StDone   = 2'd3
    } state_e;

    // Wide enough to hold SETTLE_CYCLES-1 with a bit of headroom.
    function automatic int unsigned cnt_width(input int unsigned settle);
        return $clog2(settle) + 1;
    endfunction

endpackage

// File: rtl/alu_sweep_driver_if.sv
// Operand/opcode/result bus between the sweep driver (master) and a combinational ALU (slave).
interface alu_sweep_driver_if
    import alu_sweep_driver_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDef,
    parameter int unsigned OP_W   = OpWDef
);

    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [OP_W-1:0]   c;
    logic [DATA_W-1:0] result;

    modport master (
        output src_a,
        output src_b,
        output c,
        input  result
    );

    modport slave (
        input  src_a,
        input  src_b,
        input  c,
        output result
    );

endinterface

// File: rtl/alu_sweep_driver_next_op.sv
// Priority encoder: lowest set bit of i_mask at or above i_from. i_from is one bit wider than
// an opcode so that "one past the last opcode" yields not-found instead of wrapping.
module alu_sweep_driver_next_op
    import alu_sweep_driver_pkg::*;
#(
    parameter  int unsigned OP_W    = OpWDef,
    localparam int unsigned NUM_OPS = 2 ** OP_W,
    localparam int unsigned FromW   = OP_W + 1
) (
    input  logic [NUM_OPS-1:0] i_mask,
    input  logic [FromW-1:0]   i_from,
    output logic [OP_W-1:0]    o_idx,
    output logic               o_found
);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int unsigned i = 0; i < NUM_OPS; i++) begin
            if (!o_found && i_mask[i] && (FromW'(i) >= i_from)) begin
                o_idx   = OP_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_sweep_driver.sv
// Clocked initiator for a combinational ALU: on start, drives every opcode enabled in the mask
// in ascending order, waits SETTLE_CYCLES per opcode and captures each result into a bank.
module alu_sweep_driver
    import alu_sweep_driver_pkg::*;
#(
    parameter  int unsigned DATA_W        = DataWDef,
    parameter  int unsigned OP_W          = OpWDef,
    parameter  int unsigned SETTLE_CYCLES = SettleDef,
    localparam int unsigned NUM_OPS       = 2 ** OP_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [DATA_W-1:0]  i_op_a,
    input  logic [DATA_W-1:0]  i_op_b,
    input  logic [NUM_OPS-1:0] i_op_mask,
    alu_sweep_driver_if.master alu_bus,
    output logic               o_busy,
    output logic               o_done,
    output logic [NUM_OPS-1:0] o_res_valid,
    input  logic [OP_W-1:0]    i_rd_addr,
    output logic [DATA_W-1:0]  o_rd_data
);

    localparam int unsigned         CntW    = cnt_width(SETTLE_CYCLES);
    localparam int unsigned         FromW   = OP_W + 1;
    localparam logic [CntW-1:0]     CntLoad = CntW'(SETTLE_CYCLES - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [OP_W-1:0]     r_k;
    logic [OP_W-1:0]     w_k_nxt;
    logic [CntW-1:0]     r_cnt;
    logic [CntW-1:0]     w_cnt_nxt;

    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic [NUM_OPS-1:0]  r_mask;

    logic [DATA_W-1:0]   r_src_a;
    logic [DATA_W-1:0]   r_src_b;
    logic [OP_W-1:0]     r_c;

    logic [NUM_OPS-1:0]  r_res_valid;
    logic [DATA_W-1:0]   r_res [NUM_OPS];

    logic [NUM_OPS-1:0]  w_scan_mask;
    logic [FromW-1:0]    w_from;
    logic [OP_W-1:0]     w_next_idx;
    logic                w_next_found;
    logic                w_latch;
    logic                w_drive;
    logic                w_capture;

    // In IDLE the encoder scans the incoming mask from 0; otherwise the latched mask from k+1.
    alu_sweep_driver_next_op #(
        .OP_W (OP_W)
    ) u_next_op (
        .i_mask  (w_scan_mask),
        .i_from  (w_from),
        .o_idx   (w_next_idx),
        .o_found (w_next_found)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_cnt_nxt   = r_cnt;
        w_scan_mask = r_mask;
        w_from      = FromW'(r_k) + FromW'(1);
        w_latch     = 1'b0;
        w_drive     = 1'b0;
        w_capture   = 1'b0;

        case (r_state)
            StIdle: begin
                w_scan_mask = i_op_mask;
                w_from      = '0;
                if (i_start) begin
                    w_latch     = 1'b1;
                    w_k_nxt     = w_next_idx;
                    w_state_nxt = w_next_found ? StDrive : StDone;
                end
            end
            StDrive: begin
                w_drive     = 1'b1;
                w_cnt_nxt   = CntLoad;
                w_state_nxt = StSettle;
            end
            StSettle: begin
                if (r_cnt == '0) begin
                    w_capture = 1'b1;
                    if (w_next_found) begin
                        w_k_nxt     = w_next_idx;
                        w_state_nxt = StDrive;
                    end else begin
                        w_state_nxt = StDone;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_k     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_mask      <= '0;
            r_src_a     <= '0;
            r_src_b     <= '0;
            r_c         <= '0;
            r_res_valid <= '0;
            for (int i = 0; i < NUM_OPS; i++) begin
                r_res[i] <= '0;
            end
        end else begin
            if (w_latch) begin
                r_op_a      <= i_op_a;
                r_op_b      <= i_op_b;
                r_mask      <= i_op_mask;
                r_res_valid <= '0;
            end
            if (w_drive) begin
                r_src_a <= r_op_a;
                r_src_b <= r_op_b;
                r_c     <= r_k;
            end
            if (w_capture) begin
                r_res[r_k]       <= alu_bus.result;
                r_res_valid[r_k] <= 1'b1;
            end
        end
    end

    assign alu_bus.src_a = r_src_a;
    assign alu_bus.src_b = r_src_b;
    assign alu_bus.c     = r_c;

    assign o_busy      = (r_state == StDrive) || (r_state == StSettle);
    assign o_done      = (r_state == StDone);
    assign o_res_valid = r_res_valid;
    assign o_rd_data   = r_res[i_rd_addr];

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Bench for alu_sweep_driver: two instances (settle 1 and 3) share stimulus, a behavioural ALU
// closes the loop, and a per-cycle trace model of each sweep is compared on every falling edge.
module tb_alu_sweep_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic [7:0] mask = '0;
    logic [2:0] rd_addr = '0;

    logic       busy_w  [2];
    logic       done_w  [2];
    logic [7:0] valid_w [2];
    logic [7:0] rd_w    [2];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;
    int cnt_busy [2];
    int cnt_done [2];

    always #5 clk = ~clk;

    alu_sweep_driver_if bus1 ();
    alu_sweep_driver_if bus3 ();

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] c);
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return {a[6:0], 1'b0};
            default: return {1'b0, a[7:1]};
        endcase
    endfunction

    assign bus1.result = alu_f(bus1.src_a, bus1.src_b, bus1.c);
    assign bus3.result = alu_f(bus3.src_a, bus3.src_b, bus3.c);

    alu_sweep_driver #(.SETTLE_CYCLES(1)) dut1 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_op_a      (op_a),
        .i_op_b      (op_b),
        .i_op_mask   (mask),
        .alu_bus     (bus1),
        .o_busy      (busy_w[0]),
        .o_done      (done_w[0]),
        .o_res_valid (valid_w[0]),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_w[0])
    );

    alu_sweep_driver #(.SETTLE_CYCLES(3)) dut3 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_op_a      (op_a),
        .i_op_b      (op_b),
        .i_op_mask   (mask),
        .alu_bus     (bus3),
        .o_busy      (busy_w[1]),
        .o_done      (done_w[1]),
        .o_res_valid (valid_w[1]),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_w[1])
    );

    // One entry per clock cycle of a sweep; wr marks a result becoming visible that cycle.
    typedef struct packed {
        logic       busy;
        logic       done;
        logic [2:0] c;
        logic [7:0] sa;
        logic [7:0] sb;
        logic [7:0] valid;
        logic       wr;
        logic [2:0] wk;
        logic [7:0] wd;
    } entry_t;

    entry_t     q [2][$];
    logic       m_busy  [2];
    logic       m_done  [2];
    logic [2:0] m_c     [2];
    logic [7:0] m_sa    [2];
    logic [7:0] m_sb    [2];
    logic [7:0] m_valid [2];
    logic [7:0] m_bank  [2][8];

    function automatic entry_t mk(input logic bz, input logic dn, input logic [2:0] c,
                                  input logic [7:0] sa, input logic [7:0] sb,
                                  input logic [7:0] v, input logic wr, input logic [2:0] wk,
                                  input logic [7:0] wd);
        entry_t e;
        e.busy = bz; e.done = dn; e.c = c; e.sa = sa; e.sb = sb;
        e.valid = v; e.wr = wr; e.wk = wk; e.wd = wd;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: an accepted start expands into the full cycle trace of the sweep.
    initial begin
        entry_t     e;
        logic [7:0] v, la, lb, pd;
        logic [2:0] lc, pk;
        logic       pwr;
        int         settle;
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                settle = (d == 0) ? 1 : 3;
                if (rst) begin
                    q[d].delete();
                    m_busy[d] = 0; m_done[d] = 0; m_c[d] = 0;
                    m_sa[d] = 0; m_sb[d] = 0; m_valid[d] = 0;
                    for (int k = 0; k < 8; k++) m_bank[d][k] = 0;
                end else begin
                    if (q[d].size() == 0 && !m_busy[d] && !m_done[d] && start) begin
                        v = 0; lc = m_c[d]; la = m_sa[d]; lb = m_sb[d];
                        pwr = 0; pk = 0; pd = 0;
                        for (int k = 0; k < 8; k++) begin
                            if (mask[k]) begin
                                q[d].push_back(mk(1, 0, lc, la, lb, v, pwr, pk, pd));
                                lc = 3'(k); la = op_a; lb = op_b;
                                for (int j = 0; j < settle; j++)
                                    q[d].push_back(mk(1, 0, lc, la, lb, v, 0, 0, 0));
                                v[k] = 1'b1; pwr = 1; pk = 3'(k);
                                pd = alu_f(op_a, op_b, 3'(k));
                            end
                        end
                        q[d].push_back(mk(0, 1, lc, la, lb, v, pwr, pk, pd));
                    end
                    if (q[d].size() != 0) begin
                        e = q[d].pop_front();
                        m_busy[d] = e.busy; m_done[d] = e.done; m_c[d] = e.c;
                        m_sa[d] = e.sa; m_sb[d] = e.sb; m_valid[d] = e.valid;
                        if (e.wr) m_bank[d][e.wk] = e.wd;
                    end else begin
                        m_busy[d] = 0;
                        m_done[d] = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("dut%0d busy", d), 32'(busy_w[d]), 32'(m_busy[d]));
                    chk($sformatf("dut%0d done", d), 32'(done_w[d]), 32'(m_done[d]));
                    chk($sformatf("dut%0d res_valid", d), 32'(valid_w[d]), 32'(m_valid[d]));
                    chk($sformatf("dut%0d rd_data", d), 32'(rd_w[d]),
                        32'(m_bank[d][rd_addr]));
                    chk($sformatf("dut%0d alu_c", d),
                        32'((d == 0) ? bus1.c : bus3.c), 32'(m_c[d]));
                    chk($sformatf("dut%0d alu_src_a", d),
                        32'((d == 0) ? bus1.src_a : bus3.src_a), 32'(m_sa[d]));
                    chk($sformatf("dut%0d alu_src_b", d),
                        32'((d == 0) ? bus1.src_b : bus3.src_b), 32'(m_sb[d]));
                    if (busy_w[d]) cnt_busy[d]++;
                    if (done_w[d]) cnt_done[d]++;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 2; d++) begin
            cnt_busy[d] = 0;
            cnt_done[d] = 0;
        end
    endtask

    task automatic pulse_start(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        op_a = a; op_b = b; mask = m; start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(q[0].size() == 0 && q[1].size() == 0 && !m_busy[0] && !m_busy[1] &&
                 !m_done[0] && !m_done[1]) && n < 300) begin
            step(1);
            n++;
        end
        chk("idle wait within budget", 32'(n < 300), 32'd1);
    endtask

    task automatic readback(input string name, input logic [63:0] lit);
        for (int k = 0; k < 8; k++) begin
            rd_addr = 3'(k);
            #1;
            chk($sformatf("%s dut1 res[%0d]", name, k), 32'(rd_w[0]), 32'(lit[k*8 +: 8]));
            chk($sformatf("%s dut3 res[%0d]", name, k), 32'(rd_w[1]), 32'(lit[k*8 +: 8]));
        end
        rd_addr = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "global timeout");
    end

    initial begin
        clear_counts();
        step(3);
        rst = 1'b0;
        chk_on = 1'b1;
        chk("reset busy", 32'(busy_w[0]), 32'd0);
        chk("reset res_valid", 32'(valid_w[0]), 32'd0);
        chk("reset alu_c", 32'(bus1.c), 32'd0);
        chk("reset rd_data", 32'(rd_w[0]), 32'd0);

        // Full sweep, all opcodes.
        clear_counts();
        pulse_start(8'h55, 8'h1a, 8'hFF);
        wait_idle();
        chk("full dut1 busy cycles", 32'(cnt_busy[0]), 32'd16);
        chk("full dut3 busy cycles", 32'(cnt_busy[1]), 32'd32);
        chk("full dut1 done pulses", 32'(cnt_done[0]), 32'd1);
        chk("full dut3 done pulses", 32'(cnt_done[1]), 32'd1);
        chk("full res_valid", 32'(valid_w[0]), 32'hFF);
        readback("full", 64'h2A_AA_AA_4F_5F_10_3B_6F);

        // Sparse mask: opcodes 0, 2, 7 only.
        clear_counts();
        pulse_start(8'h55, 8'h1a, 8'b1000_0101);
        wait_idle();
        chk("sparse dut1 busy cycles", 32'(cnt_busy[0]), 32'd6);
        chk("sparse dut3 busy cycles", 32'(cnt_busy[1]), 32'd12);
        chk("sparse res_valid", 32'(valid_w[0]), 32'h85);
        chk("sparse last alu_c", 32'(bus1.c), 32'd7);

        // Zero mask: done one cycle after start, no ALU traffic.
        clear_counts();
        op_a = 8'h33; op_b = 8'h44; mask = 8'h00; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("zero done next cycle", 32'(done_w[0]), 32'd1);
        wait_idle();
        chk("zero busy cycles", 32'(cnt_busy[0] + cnt_busy[1]), 32'd0);
        chk("zero done pulses", 32'(cnt_done[0]), 32'd1);
        chk("zero alu_c unchanged", 32'(bus1.c), 32'd7);
        chk("zero res_valid", 32'(valid_w[0]), 32'd0);

        // start held through dut1's sweep and DONE: exactly one sweep each.
        clear_counts();
        op_a = 8'h12; op_b = 8'h34; mask = 8'h11; start = 1'b1;
        step(6);
        start = 1'b0;
        wait_idle();
        chk("held dut1 done pulses", 32'(cnt_done[0]), 32'd1);
        chk("held dut3 done pulses", 32'(cnt_done[1]), 32'd1);
        chk("held dut1 busy cycles", 32'(cnt_busy[0]), 32'd4);
        clear_counts();
        pulse_start(8'hFF, 8'h01, 8'hFF);
        wait_idle();
        chk("second sweep done pulses", 32'(cnt_done[0]), 32'd1);
        readback("second", 64'h7F_FE_00_FE_FF_01_FE_00);

        // Reset on the 5th busy cycle of a full sweep.
        clear_counts();
        pulse_start(8'h55, 8'h1a, 8'hFF);
        step(4);
        rst = 1'b1;
        step(1);
        chk("rst busy", 32'(busy_w[0]), 32'd0);
        chk("rst done", 32'(done_w[0]), 32'd0);
        chk("rst res_valid", 32'(valid_w[0]), 32'd0);
        chk("rst alu_c", 32'(bus1.c), 32'd0);
        chk("rst alu_src_a", 32'(bus1.src_a), 32'd0);
        chk("rst rd_data", 32'(rd_w[0]), 32'd0);
        rst = 1'b0;
        step(8);
        chk("rst no done pulse", 32'(cnt_done[0] + cnt_done[1]), 32'd0);

        // Two-opcode sweep shows the settle-3 timing.
        clear_counts();
        pulse_start(8'h55, 8'h1a, 8'h03);
        wait_idle();
        chk("mask03 dut1 busy cycles", 32'(cnt_busy[0]), 32'd4);
        chk("mask03 dut3 busy cycles", 32'(cnt_busy[1]), 32'd8);
        chk("mask03 res_valid", 32'(valid_w[1]), 32'h03);
        rd_addr = 3'd0;
        #1;
        chk("mask03 dut3 res[0]", 32'(rd_w[1]), 32'h6F);
        rd_addr = 3'd1;
        #1;
        chk("mask03 dut3 res[1]", 32'(rd_w[1]), 32'h3B);
        rd_addr = 3'd2;
        #1;
        chk("mask03 stale res[2]", 32'(rd_w[1]), 32'h00);

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
